// File: rtl/fft_pass_sched_if.sv
// Control bundle between the frame controller / pass engines and fft_pass_sched.
// master = the scheduler side, slave = the frame controller and pass engines.
interface fft_pass_sched_if #(
  parameter int FRAME_CNT_W = 16
);
  logic                   frame_start;
  logic                   abort;
  logic [3:0]             pass_done;
  logic [1:0]             fft_state;
  logic [3:0]             pass_start;
  logic                   busy;
  logic                   frame_done;
  logic                   timeout_err;
  logic [FRAME_CNT_W-1:0] frame_cnt;

  modport master (
    input  frame_start, abort, pass_done,
    output fft_state, pass_start, busy, frame_done, timeout_err, frame_cnt
  );

  modport slave (
    output frame_start, abort, pass_done,
    input  fft_state, pass_start, busy, frame_done, timeout_err, frame_cnt
  );
endinterface

// File: rtl/fft_pass_sched.sv
// Runs the four FFT passes over the shared ROI banks; outputs registered, pass_start[0] one cycle after frame_start.
// No backpressure: frame_start while busy is dropped; FFT_SCHED_TIMEOUT_EN adds a per-pass RUN watchdog.
module fft_pass_sched #(
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int FRAME_CNT_W    = 16
) (
  input  logic             s_axi_aclk,
  input  logic             s_axi_areset,
  fft_pass_sched_if.master bus
);
  typedef enum logic [2:0] {IDLE, START, RUN, GAP, DONE} state_t;

  state_t                 state, nextState;
  logic [1:0]             pass, nextPass;
  logic [7:0]             gapCnt, nextGapCnt;
  logic [1:0]             fftStateQ;
  logic [3:0]             passStartQ;
  logic                   busyQ;
  logic                   frameDoneQ;
  logic [FRAME_CNT_W-1:0] frameCntQ;
`ifdef FFT_SCHED_TIMEOUT_EN
  logic [19:0]            wdCnt;
  logic                   timeoutHit;
  logic                   timeoutErrQ;
`endif

  always_comb begin
    nextState  = state;
    nextPass   = pass;
    nextGapCnt = gapCnt;
`ifdef FFT_SCHED_TIMEOUT_EN
    timeoutHit = 1'b0;
`endif
    // abort outranks everything except an IDLE frame_start
    if (bus.abort && state != IDLE) begin
      nextState = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (bus.frame_start) begin
            nextState = START;
            nextPass  = 2'd0;
          end
        end
        START: nextState = RUN;
        RUN: begin
          if (bus.pass_done[pass]) begin
            if (pass == 2'd3) begin
              nextState = DONE;
            end else if (GAP_CYCLES == 0) begin
              nextState = START;
              nextPass  = pass + 2'd1;
            end else begin
              nextState  = GAP;
              nextGapCnt = 8'(GAP_CYCLES);
            end
          end
`ifdef FFT_SCHED_TIMEOUT_EN
          else if (wdCnt == 20'(TIMEOUT_CYCLES - 1)) begin
            nextState  = IDLE;
            timeoutHit = 1'b1;
          end
`endif
        end
        GAP: begin
          if (gapCnt == 8'd1) begin
            nextState = START;
            nextPass  = pass + 2'd1;
          end else begin
            nextGapCnt = gapCnt - 8'd1;
          end
        end
        DONE:    nextState = IDLE;
        default: nextState = IDLE;
      endcase
    end
  end

  // Outputs are loaded from the next-state decode so they line up with the state they describe.
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      state      <= IDLE;
      pass       <= 2'd0;
      gapCnt     <= 8'd0;
      fftStateQ  <= 2'd0;
      passStartQ <= 4'd0;
      busyQ      <= 1'b0;
      frameDoneQ <= 1'b0;
      frameCntQ  <= '0;
    end else begin
      state      <= nextState;
      pass       <= nextPass;
      gapCnt     <= nextGapCnt;
      fftStateQ  <= (nextState == IDLE) ? 2'd0 : nextPass;
      passStartQ <= (nextState == START) ? (4'b0001 << nextPass) : 4'd0;
      busyQ      <= (nextState != IDLE);
      frameDoneQ <= (nextState == DONE);
      if (nextState == DONE) begin
        frameCntQ <= frameCntQ + FRAME_CNT_W'(1);
      end
    end
  end

`ifdef FFT_SCHED_TIMEOUT_EN
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      wdCnt       <= 20'd0;
      timeoutErrQ <= 1'b0;
    end else begin
      if (nextState == START) begin
        wdCnt <= 20'd0;
      end else if (state == RUN) begin
        wdCnt <= wdCnt + 20'd1;
      end
      if (state == IDLE && bus.frame_start) begin
        timeoutErrQ <= 1'b0;
      end else if (timeoutHit) begin
        timeoutErrQ <= 1'b1;
      end
    end
  end

  assign bus.timeout_err = timeoutErrQ;
`else
  // No watchdog built: reads as 0 for any legal TIMEOUT_CYCLES.
  assign bus.timeout_err = 1'(TIMEOUT_CYCLES < 0);
`endif

  assign bus.fft_state  = fftStateQ;
  assign bus.pass_start = passStartQ;
  assign bus.busy       = busyQ;
  assign bus.frame_done = frameDoneQ;
  assign bus.frame_cnt  = frameCntQ;
endmodule

// File: tb/tb_fft_pass_sched.sv
// Drives two schedulers (GAP_CYCLES 4 and 0) from shared controls; pass engines answer 10 cycles after each start.
module tb_fft_pass_sched;
  localparam int LAT = 10;
  localparam int BIG = 1 << 30;

  typedef struct {
    int inst;
    int at;
    int kind;   // 0..3 = pass_start[k], 4 = frame_done
    int cnt;
  } evt_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frameStart = 1'b0;
  logic       abortReq = 1'b0;
  logic [3:0] strayDone = 4'd0;
  logic [3:0] respDone [2] = '{4'd0, 4'd0};
  bit         respEn = 1'b1;
  int         cyc = 0;
  int         doneAt [2][4];
  int         lastFd [2] = '{-1000, -1000};
  int         expCnt [2] = '{0, 0};
  int         nChecks = 0;
  int         nErrors = 0;
  int         t0;
  evt_t       expQ[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fft_pass_sched_if #(.FRAME_CNT_W(16)) b4 ();
  fft_pass_sched_if #(.FRAME_CNT_W(16)) b0 ();

  assign b4.frame_start = frameStart;
  assign b4.abort       = abortReq;
  assign b4.pass_done   = respDone[0] | strayDone;
  assign b0.frame_start = frameStart;
  assign b0.abort       = abortReq;
  assign b0.pass_done   = respDone[1] | strayDone;

  fft_pass_sched #(.GAP_CYCLES(4), .TIMEOUT_CYCLES(100), .FRAME_CNT_W(16)) dutG4 (
    .s_axi_aclk(clk), .s_axi_areset(rst), .bus(b4));
  fft_pass_sched #(.GAP_CYCLES(0), .TIMEOUT_CYCLES(100), .FRAME_CNT_W(16)) dutG0 (
    .s_axi_aclk(clk), .s_axi_areset(rst), .bus(b0));

  task automatic checkEq(input string tag, input longint obs, input longint exp);
    nChecks++;
    if (obs !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int findHead(input int inst);
    for (int i = 0; i < expQ.size(); i++)
      if (expQ[i].inst == inst) return i;
    return -1;
  endfunction

  // Expected events for one frame started in cycle s0; events after lastCyc are cut off (abort/reset/timeout).
  task automatic pushFrame(input int s0, input int lastCyc);
    for (int inst = 0; inst < 2; inst++) begin
      int g = (inst == 0) ? 4 : 0;
      int s = s0 + 1;
      int fd;
      for (int k = 0; k < 4; k++) begin
        if (s <= lastCyc) expQ.push_back('{inst, s, k, 0});
        if (k < 3) s = s + LAT + 1 + g;
      end
      fd = s + LAT + 1;
      if (fd <= lastCyc) begin
        expCnt[inst]++;
        expQ.push_back('{inst, fd, 4, expCnt[inst] & 16'hFFFF});
      end
    end
  endtask

  task automatic observe(input int inst, input logic [3:0] ps, input logic fd, input logic bz,
                         input logic [1:0] st, input logic [15:0] cnt);
    int h = findHead(inst);
    int kind = 4;
    while (h >= 0 && expQ[h].at < cyc) begin
      checkEq($sformatf("missedEvt%0d_k%0d", inst, expQ[h].kind), cyc, expQ[h].at);
      expQ.delete(h);
      h = findHead(inst);
    end
    if (ps != 4'd0 || fd) begin
      for (int k = 0; k < 4; k++) if (ps[k]) kind = k;
      checkEq($sformatf("oneHot%0d", inst), $countones(ps) + int'(fd), 1);
      if (h < 0) begin
        checkEq($sformatf("unexpectedEvt%0d", inst), kind, -1);
      end else begin
        checkEq($sformatf("evtKind%0d", inst), kind, expQ[h].kind);
        checkEq($sformatf("evtCycle%0d_k%0d", inst, kind), cyc, expQ[h].at);
        checkEq($sformatf("busyAtEvt%0d", inst), bz, 1);
        checkEq($sformatf("fftStateAtEvt%0d", inst), st, (kind == 4) ? 3 : kind);
        if (kind == 4) checkEq($sformatf("frameCnt%0d", inst), cnt, expQ[h].cnt);
        expQ.delete(h);
      end
      if (kind < 4) doneAt[inst][kind] = cyc + LAT;
      if (fd) lastFd[inst] = cyc;
    end
    if (cyc == lastFd[inst] + 1) begin
      checkEq($sformatf("busyAfterDone%0d", inst), bz, 0);
      checkEq($sformatf("fftStateAfterDone%0d", inst), st, 0);
    end
  endtask

  always @(negedge clk) begin
    observe(0, b4.pass_start, b4.frame_done, b4.busy, b4.fft_state, b4.frame_cnt);
    observe(1, b0.pass_start, b0.frame_done, b0.busy, b0.fft_state, b0.frame_cnt);
  end

  // Pass engine model: done[k] LAT cycles after the matching pass_start[k].
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 4; k++)
        respDone[i][k] = respEn && (cyc == doneAt[i][k]);
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkIdle(input string tag);
    checkEq({tag, "_fftState4"}, b4.fft_state, 0);
    checkEq({tag, "_passStart4"}, b4.pass_start, 0);
    checkEq({tag, "_busy4"}, b4.busy, 0);
    checkEq({tag, "_frameDone4"}, b4.frame_done, 0);
    checkEq({tag, "_timeoutErr4"}, b4.timeout_err, 0);
    checkEq({tag, "_frameCnt4"}, b4.frame_cnt, expCnt[0]);
    checkEq({tag, "_fftState0"}, b0.fft_state, 0);
    checkEq({tag, "_passStart0"}, b0.pass_start, 0);
    checkEq({tag, "_busy0"}, b0.busy, 0);
    checkEq({tag, "_frameDone0"}, b0.frame_done, 0);
    checkEq({tag, "_timeoutErr0"}, b0.timeout_err, 0);
    checkEq({tag, "_frameCnt0"}, b0.frame_cnt, expCnt[1]);
  endtask

  task automatic runFrame(input bit withAbort);
    nextCycle();
    t0 = cyc;
    frameStart = 1'b1;
    abortReq = withAbort;
    pushFrame(t0, BIG);
    nextCycle();
    frameStart = 1'b0;
    abortReq = 1'b0;
    repeat (62) nextCycle();
  endtask

  initial begin
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 4; k++) doneAt[i][k] = -1000;
    repeat (3) nextCycle();
    rst = 1'b0;
    nextCycle();
    checkIdle("reset");

    runFrame(1'b0);

    // stray pass_done[2] and a second frame_start while pass 1 runs
    nextCycle();
    t0 = cyc;
    frameStart = 1'b1;
    pushFrame(t0, BIG);
    nextCycle();
    frameStart = 1'b0;
    while (cyc < t0 + 18) nextCycle();
    strayDone = 4'b0100;
    frameStart = 1'b1;
    nextCycle();
    strayDone = 4'd0;
    frameStart = 1'b0;
    checkEq("strayState4", b4.fft_state, 1);
    checkEq("strayState0", b0.fft_state, 1);
    repeat (50) nextCycle();

    // abort together with pass_done[2] (GAP 4 unit); GAP 0 unit is in pass 3
    nextCycle();
    t0 = cyc;
    frameStart = 1'b1;
    pushFrame(t0, t0 + 41);
    nextCycle();
    frameStart = 1'b0;
    while (cyc < t0 + 41) nextCycle();
    abortReq = 1'b1;
    nextCycle();
    abortReq = 1'b0;
    checkIdle("abort");
    repeat (20) nextCycle();

    // abort alone in IDLE does nothing; abort with frame_start starts the frame
    abortReq = 1'b1;
    nextCycle();
    abortReq = 1'b0;
    nextCycle();
    checkIdle("idleAbort");
    runFrame(1'b1);

    // reset while the GAP 4 unit drains after pass 1
    nextCycle();
    t0 = cyc;
    frameStart = 1'b1;
    pushFrame(t0, t0 + 28);
    nextCycle();
    frameStart = 1'b0;
    while (cyc < t0 + 28) nextCycle();
    rst = 1'b1;
    nextCycle();
    rst = 1'b0;
    expCnt = '{0, 0};
    checkIdle("midReset");
    repeat (20) nextCycle();
    runFrame(1'b0);

`ifdef FFT_SCHED_TIMEOUT_EN
    respEn = 1'b0;
    nextCycle();
    t0 = cyc;
    frameStart = 1'b1;
    pushFrame(t0, t0 + 1);
    nextCycle();
    frameStart = 1'b0;
    while (cyc < t0 + 101) nextCycle();
    checkEq("wdBefore4", b4.timeout_err, 0);
    checkEq("wdBusy4", b4.busy, 1);
    nextCycle();
    checkEq("wdFired4", b4.timeout_err, 1);
    checkEq("wdFired0", b0.timeout_err, 1);
    checkEq("wdIdle4", b4.busy, 0);
    checkEq("wdIdle0", b0.busy, 0);
    respEn = 1'b1;
    repeat (3) nextCycle();
    nextCycle();
    t0 = cyc;
    frameStart = 1'b1;
    pushFrame(t0, BIG);
    nextCycle();
    frameStart = 1'b0;
    checkEq("wdClear4", b4.timeout_err, 0);
    checkEq("wdClear0", b0.timeout_err, 0);
    repeat (62) nextCycle();
`endif

    checkEq("scoreboardEmpty", expQ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end
endmodule
